// File: rtl/sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sequencer_pkg
//  Description : Shared definitions for call_return_sequencer: FSM state
//                encoding and the number of stack bytes per call frame.
//                Ports: none (package).
//  Revision    : 1.0  initial release
// ============================================================================
package sequencer_pkg;

    // Each frame is the return address followed by the flags byte.
    localparam int FRAME_BYTES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_PC = 3'd1,
        ST_PUSH_FL = 3'd2,
        ST_POP_FL  = 3'd3,
        ST_POP_PC  = 3'd4,
        ST_CAP_PC  = 3'd5,
        ST_FIN     = 3'd6
    } state_e;

endpackage : sequencer_pkg
`default_nettype wire

// File: rtl/call_return_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : call_return_sequencer
//  Description : Saves (Call) and restores (Ret) a two-byte call frame
//                (return address, flags) through an external byte-wide stack.
//  Ports       : clk, Reset (sync, active-low)
//                Call, Ret           - requests, sampled in IDLE only
//                ReturnAddr, FlagsIn - frame contents saved on Call
//                StackDataout        - stack read data, valid the cycle after
//                                      StackRead
//                StackWrite, StackRead, StackDatain - stack strobes / data
//                Busy, Done, Overflow, Underflow    - sequence status
//                PCOut, FlagsOut     - last restored frame
//                Depth               - frames currently on the stack
//  Revision    : 1.0  initial release
// ============================================================================
module call_return_sequencer
    import sequencer_pkg::*;
#(
    parameter int MAX_FRAMES = 127
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Call,
    input  logic       Ret,
    input  logic [7:0] ReturnAddr,
    input  logic [7:0] FlagsIn,
    input  logic [7:0] StackDataout,
    output logic       StackWrite,
    output logic       StackRead,
    output logic [7:0] StackDatain,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] PCOut,
    output logic [7:0] FlagsOut,
    output logic       Overflow,
    output logic       Underflow,
    output logic [7:0] Depth
);

    localparam logic [7:0] MAX_DEPTH = 8'(MAX_FRAMES);

    state_e     state_q,   state_d;
    logic [7:0] addr_q,    addr_d;
    logic [7:0] flags_q,   flags_d;
    logic [7:0] depth_q,   depth_d;
    logic [7:0] pc_q,      pc_d;
    logic [7:0] flout_q,   flout_d;
    logic       ovf_q,     ovf_d;
    logic       unf_q,     unf_d;
    logic       wr_q,      wr_d;
    logic       rd_q,      rd_d;
    logic [7:0] datain_q,  datain_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        flags_d = flags_q;
        depth_d = depth_q;
        pc_d    = pc_q;
        flout_d = flout_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Call has priority; a simultaneous Ret is simply dropped.
                if (Call) begin
                    if (depth_q < MAX_DEPTH) begin
                        addr_d  = ReturnAddr;
                        flags_d = FlagsIn;
                        state_d = ST_PUSH_PC;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end else if (Ret) begin
                    if (depth_q != 8'd0) begin
                        state_d = ST_POP_FL;
                    end else begin
                        unf_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_PUSH_PC: state_d = ST_PUSH_FL;
            ST_PUSH_FL: begin
                if (depth_q < MAX_DEPTH) begin
                    depth_d = depth_q + 8'd1;
                end
                state_d = ST_FIN;
            end
            ST_POP_FL:  state_d = ST_POP_PC;
            ST_POP_PC: begin
                // Data for the POP_FL strobe arrives now: flags were pushed last.
                flout_d = StackDataout;
                state_d = ST_CAP_PC;
            end
            ST_CAP_PC: begin
                pc_d = StackDataout;
                if (depth_q != 8'd0) begin
                    depth_d = depth_q - 8'd1;
                end
                state_d = ST_FIN;
            end
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered so
        // they line up with that state's cycle.
        wr_d     = (state_d == ST_PUSH_PC) || (state_d == ST_PUSH_FL);
        rd_d     = (state_d == ST_POP_FL)  || (state_d == ST_POP_PC);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_FIN);
        datain_d = (state_d == ST_PUSH_PC) ? addr_d  :
                   (state_d == ST_PUSH_FL) ? flags_d : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 8'h00;
            flags_q  <= 8'h00;
            depth_q  <= 8'h00;
            pc_q     <= 8'h00;
            flout_q  <= 8'h00;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            datain_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            flags_q  <= flags_d;
            depth_q  <= depth_d;
            pc_q     <= pc_d;
            flout_q  <= flout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            datain_q <= datain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign StackWrite  = wr_q;
    assign StackRead   = rd_q;
    assign StackDatain = datain_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign PCOut       = pc_q;
    assign FlagsOut    = flout_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;
    assign Depth       = depth_q;

endmodule : call_return_sequencer
`default_nettype wire
